// File: rtl/alu4_op_arbiter_if.sv
// alu4_op_arbiter_if
//   Bundle between the two operand sources and the shared ALU controller.
//
//   Requesters drive:   req0/op0/a0/b0, req1/op1/a1/b1
//   Controller drives:  gnt[1:0], busy, done, done_id, result[2*WIDTH-1:0],
//                       carry, zero, err, state_dbg[1:0]
//
//   Handshake: a requester raises reqN as a level with its op/operands and
//   holds it until it sees done with done_id==N. The operands are sampled
//   only on the edge where gnt[N] rises. The edge that follows the done
//   cycle returns the unit to idle. At that edge the requester either drops
//   reqN or presents its next op. done is a single-cycle pulse.
//   result/carry/zero/err are valid with done and hold until the next done.
//   state_dbg mirrors the controller FSM state (0 IDLE, 1 EXEC, 2 MUL, 3 DONE).
interface alu4_op_arbiter_if #(
    parameter int WIDTH = 4
);
    logic                 req0;
    logic [2:0]           op0;
    logic [WIDTH-1:0]     a0;
    logic [WIDTH-1:0]     b0;
    logic                 req1;
    logic [2:0]           op1;
    logic [WIDTH-1:0]     a1;
    logic [WIDTH-1:0]     b1;
    logic [1:0]           gnt;
    logic                 busy;
    logic                 done;
    logic                 done_id;
    logic [2*WIDTH-1:0]   result;
    logic                 carry;
    logic                 zero;
    logic                 err;
    logic [1:0]           state_dbg;

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1,
        input  gnt, busy, done, done_id, result, carry, zero, err, state_dbg
    );

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1,
        output gnt, busy, done, done_id, result, carry, zero, err, state_dbg
    );
endinterface

// File: rtl/alu4_op_arbiter.sv
// alu4_op_arbiter
//   Shares one WIDTH-bit ALU (AND/OR/XOR/ADD/SUB, shift-add MUL) between two
//   requesters. It arbitrates round-robin, captures the winner's operands and
//   sequences the op. It returns a one-cycle done pulse with the result and
//   flags to the winner.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu4_op_arbiter_if.slave (requests in; grant/status/result out)
//
//   All outputs are registered.
module alu4_op_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu4_op_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic               last_q, last_d;     // requester granted most recently
    logic               win_q, win_d;       // owner of the current op
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RW-1:0]      acc_q, acc_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               done_id_q, done_id_d;
    logic [RW-1:0]      result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;

    // Arbitration: the sole requester wins. On a tie the requester that did
    // not win last time wins.
    logic req_any;
    logic pick;
    assign req_any = bus.req0 | bus.req1;
    assign pick    = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

    // Single-cycle datapath on the latched operands. The extra top bit of
    // sub_w is the borrow, because it is set exactly when a < b.
    logic [WIDTH:0]  add_w;
    logic [WIDTH:0]  sub_w;
    logic [RW-1:0]   exec_res;
    logic            exec_carry;
    logic            exec_err;

    assign add_w = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        exec_res   = '0;
        exec_carry = 1'b0;
        exec_err   = 1'b0;
        case (op_q)
            OP_AND: exec_res = {{WIDTH{1'b0}}, a_q & b_q};
            OP_OR:  exec_res = {{WIDTH{1'b0}}, a_q | b_q};
            OP_XOR: exec_res = {{WIDTH{1'b0}}, a_q ^ b_q};
            OP_ADD: begin
                exec_res   = {{WIDTH{1'b0}}, add_w[WIDTH-1:0]};
                exec_carry = add_w[WIDTH];
            end
            OP_SUB: begin
                exec_res   = {{WIDTH{1'b0}}, sub_w[WIDTH-1:0]};
                exec_carry = sub_w[WIDTH];
            end
            default: exec_err = 1'b1;   // illegal opcodes (MUL never reaches EXEC)
        endcase
    end

    // Shift-add multiply: iteration cnt adds a << cnt when multiplier bit cnt
    // is set, so the LSB of the multiplier is consumed first.
    logic [RW-1:0] a_ext;
    logic [RW-1:0] partial;
    logic [RW-1:0] acc_sum;

    assign a_ext   = {{WIDTH{1'b0}}, a_q};
    assign partial = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
    assign acc_sum = acc_q + partial;

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_d     = win_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        gnt_d     = gnt_q;
        done_d    = done_q;
        done_id_d = done_id_q;
        result_d  = result_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    win_d  = pick;
                    last_d = pick;
                    op_d   = pick ? bus.op1 : bus.op0;
                    a_d    = pick ? bus.a1  : bus.a0;
                    b_d    = pick ? bus.b1  : bus.b0;
                    gnt_d  = pick ? 2'b10 : 2'b01;
                    if ((pick ? bus.op1 : bus.op0) == OP_MUL) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                result_d  = exec_res;
                carry_d   = exec_carry;
                zero_d    = (exec_res == '0);
                err_d     = exec_err;
                done_d    = 1'b1;
                done_id_d = win_q;
                state_d   = DONE;
            end
            MUL: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = acc_sum;
                if (cnt_q == CNT_LAST) begin
                    result_d  = acc_sum;
                    carry_d   = 1'b0;
                    zero_d    = (acc_sum == '0);
                    err_d     = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = win_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // This is the cooldown cycle. No arbitration happens here, so
                // a requester still holding req for the op it just finished
                // cannot be issued twice.
                done_d  = 1'b0;
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            win_q     <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_q     <= win_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            err_q     <= err_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_alu4_op_arbiter.sv
// tb_alu4_op_arbiter
//   Directed bench for alu4_op_arbiter (WIDTH=4). Each issued op pushes its
//   expected {done_id, err, zero, carry, result} onto exp_q. A monitor pops
//   one entry on every done pulse and compares it with the DUT payload.
//   Latency, grant, busy, reset and hold behaviour are checked inline.
module tb_alu4_op_arbiter;

    localparam int WIDTH = 4;
    localparam int EW    = 1 + 1 + 1 + 1 + 2 * WIDTH;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_BAD = 3'b111;

    logic clk;
    logic rst_n;

    alu4_op_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu4_op_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("%s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model. It works on plain integers and does not use the RTL's
    // bit tricks.
    function automatic logic [EW-1:0] model(input logic id, input logic [2:0] op,
                                            input logic [3:0] a, input logic [3:0] b);
        int ai;
        int bi;
        int r;
        logic c;
        logic e;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        c  = 1'b0;
        e  = 1'b0;
        case (op)
            OP_AND: r = ai & bi;
            OP_OR:  r = ai | bi;
            OP_XOR: r = ai ^ bi;
            OP_ADD: begin r = (ai + bi) % 16;      c = (ai + bi) > 15; end
            OP_SUB: begin r = (ai - bi + 16) % 16; c = (ai < bi);      end
            OP_MUL: r = ai * bi;
            default: begin r = 0; e = 1'b1; end
        endcase
        return {id, e, (r == 0), c, 8'(r)};
    endfunction

    logic [EW-1:0] mon_obs;
    logic [EW-1:0] mon_exp;

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            mon_obs = {bus.done_id, bus.err, bus.zero, bus.carry, bus.result};
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("done_payload", 32'(mon_obs), 32'(mon_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic id, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic expect_done);
        if (id == 1'b0) begin
            bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b;
        end else begin
            bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b;
        end
        if (expect_done) exp_q.push_back(model(id, op, a, b));
    endtask

    // Counts negedges until done is seen (bounded); busy_cnt counts busy cycles.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) busy_cnt++;
            if (bus.done) break;
        end
        if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt),       32'd0);
        check({tag, "_busy"},  32'(bus.busy),      32'd0);
        check({tag, "_done"},  32'(bus.done),      32'd0);
        check({tag, "_state"}, 32'(bus.state_dbg), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_idle(tag);
        check({tag, "_done_id"}, 32'(bus.done_id), 32'd0);
        check({tag, "_result"},  32'(bus.result),  32'd0);
        check({tag, "_carry"},   32'(bus.carry),   32'd0);
        check({tag, "_zero"},    32'(bus.zero),    32'd0);
        check({tag, "_err"},     32'(bus.err),     32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issues one op from a single requester, then checks latency, grant, busy
    // span, the done pulse width and that the result holds after done.
    task automatic run_single(input string tag, input logic id, input logic [2:0] op,
                              input logic [3:0] a, input logic [3:0] b, input int exp_lat);
        int cyc;
        int bc;
        logic [EW-1:0] e;
        e = model(id, op, a, b);
        drive(id, op, a, b, 1'b1);
        wait_done(cyc, bc);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_lat));
        check({tag, "_gnt"}, 32'(bus.gnt), id ? 32'd2 : 32'd1);
        if (id == 1'b0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        @(negedge clk);
        check_idle({tag, "_after"});
        check({tag, "_hold"}, 32'({bus.err, bus.zero, bus.carry, bus.result}), 32'(e[EW-2:0]));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int bc;
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.op0 = '0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.op1 = '0; bus.a1 = '0; bus.b1 = '0;

        apply_reset();

        run_single("add_9_8",   1'b0, OP_ADD, 4'd9,  4'd8,  2);
        run_single("sub_3_5",   1'b1, OP_SUB, 4'd3,  4'd5,  2);
        run_single("sub_5_3",   1'b1, OP_SUB, 4'd5,  4'd3,  2);
        run_single("mul_5_3",   1'b0, OP_MUL, 4'd5,  4'd3,  5);
        run_single("mul_15_15", 1'b0, OP_MUL, 4'd15, 4'd15, 5);
        run_single("illegal",   1'b1, OP_BAD, 4'd3,  4'd4,  2);
        run_single("err_clear", 1'b0, OP_ADD, 4'd1,  4'd1,  2);

        // Simultaneous requests right after reset: requester 0 wins the first tie.
        apply_reset();
        drive(1'b0, OP_OR,  4'hA, 4'h5, 1'b1);
        drive(1'b1, OP_AND, 4'hC, 4'hA, 1'b1);
        wait_done(cyc, bc);
        check("tie1_lat", 32'(cyc), 32'd2);
        check("tie1_gnt", 32'(bus.gnt), 32'd1);
        // Both requests are still held. The cooldown cycle, then requester 1.
        wait_done(cyc, bc);
        check("tie2_lat", 32'(cyc), 32'd3);
        check("tie2_gnt", 32'(bus.gnt), 32'd2);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        check_idle("tie_gap");

        // Re-raise both: requester 0 wins again.
        drive(1'b0, OP_ADD, 4'd2,  4'd3, 1'b1);
        drive(1'b1, OP_XOR, 4'hF, 4'h1, 1'b1);
        wait_done(cyc, bc);
        check("rr1_lat", 32'(cyc), 32'd2);
        check("rr1_gnt", 32'(bus.gnt), 32'd1);
        bus.req0 = 1'b0;
        wait_done(cyc, bc);
        check("rr2_lat", 32'(cyc), 32'd3);
        check("rr2_gnt", 32'(bus.gnt), 32'd2);
        bus.req1 = 1'b0;
        @(negedge clk);
        check_idle("rr_end");

        // Reset during the second MUL iteration. The op is aborted, so no done
        // is expected and nothing is pushed.
        drive(1'b0, OP_MUL, 4'd7, 4'd6, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mid_mul_state", 32'(bus.state_dbg), 32'd2);
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_single("xor_6_6", 1'b1, OP_XOR, 4'h6, 4'h6, 2);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
